// File: rtl/serial_tx_scheduler.sv
// serial_tx_scheduler: round-robin arbiter that feeds one serial transmitter a word per frame
module serial_tx_scheduler #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_W       = 7,
  parameter int FRAME_CYCLES = 10,
  parameter int GAP_CYCLES   = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic                      tx_start,
  output logic [DATA_W-1:0]         tx_data,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        ack,
  output logic                      busy
);
  localparam int PW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CMAX = (FRAME_CYCLES > GAP_CYCLES + 1) ? FRAME_CYCLES : GAP_CYCLES + 1;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_t;
  state_t state, state_nx;
  logic [PW-1:0] ptr, win, idx;
  logic [CW-1:0] cnt;
  logic          cnt_zero;
  assign cnt_zero = cnt == '0;
  assign tx_start = state == LOAD;
  assign busy     = state != IDLE;
  assign ack      = (state == SEND && cnt_zero) ? grant : '0;
  // Pick the first pending requester at or after ptr; scanning downward lets the nearest one win.
  always_comb begin
    win = ptr;
    idx = ptr;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = PW'((int'(ptr) + i) % NUM_REQ);
      if (req[idx]) win = idx;
    end
  end
  // State register; reset abandons any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  // Next-state: one LOAD cycle, counted SEND, optional counted GAP.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = |req ? LOAD : IDLE;
      LOAD:    state_nx = SEND;
      SEND:    state_nx = cnt_zero ? ((GAP_CYCLES > 0) ? GAP : IDLE) : SEND;
      GAP:     state_nx = cnt_zero ? IDLE : GAP;
      default: state_nx = IDLE;
    endcase
  end
  // Capture winner and word in IDLE, then run the frame and gap counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr     <= '0;
      grant   <= '0;
      tx_data <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: if (|req) begin
          grant   <= NUM_REQ'(1) << win;
          tx_data <= req_data[int'(win)*DATA_W +: DATA_W];
          ptr     <= (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
        end
        LOAD: cnt <= CW'(FRAME_CYCLES - 2);
        SEND: if (cnt_zero) begin
          grant <= '0;
          cnt   <= CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
        end else cnt <= cnt - 1'b1;
        GAP: if (!cnt_zero) cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_tx_scheduler.sv
// tb_serial_tx_scheduler: scoreboard bench checking grants, words, ack timing and reset behaviour
module tb_serial_tx_scheduler;
  localparam int N = 4;
  localparam int W = 7;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [N-1:0] req = '0;
  logic [N*W-1:0] req_data = '0;
  logic tx_start, busy;
  logic [W-1:0] tx_data;
  logic [N-1:0] grant, ack;
  serial_tx_scheduler #(.NUM_REQ(N), .DATA_W(W), .FRAME_CYCLES(10), .GAP_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data),
    .tx_start(tx_start), .tx_data(tx_data), .grant(grant), .ack(ack), .busy(busy)
  );
  always #5 clk = ~clk;
  typedef struct {logic [N-1:0] g; logic [W-1:0] d;} exp_t;
  exp_t q[$];
  exp_t e;
  int starts[$];
  int n_cmp = 0, n_bad = 0, cyc = 0, acks = 0, last_start = 0;
  logic [N-1:0] last_g = '0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  always @(posedge clk) cyc++;
  // Scoreboard monitor: each start pops an expected owner/word; each ack must follow its start by 9 cycles.
  always @(negedge clk) if (rst_n) begin
    if (tx_start) begin
      chk("start_expected", 32'(q.size() > 0), 1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("grant", 32'(grant), 32'(e.g));
        chk("tx_data", 32'(tx_data), 32'(e.d));
      end
      chk("start_ack_excl", 32'(ack), 0);
      last_g = grant;
      last_start = cyc;
      starts.push_back(cyc);
    end
    if (ack != '0) begin
      chk("ack_owner", 32'(ack), 32'(last_g));
      chk("ack_latency", 32'(cyc - last_start), 9);
      acks++;
    end
  end
  task automatic set_word(input int i, input logic [W-1:0] d);
    req_data[i*W +: W] = d;
  endtask
  task automatic wait_start();
    int n = 0;
    @(negedge clk);
    while (!tx_start && n < 60) begin
      n++;
      @(negedge clk);
    end
    if (!tx_start) chk("start_timeout", 32'(tx_start), 1);
  endtask
  task automatic wait_idle();
    int n = 0;
    while (busy && n < 60) begin
      n++;
      @(negedge clk);
    end
    chk("idle_timeout", 32'(busy), 0);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1 chk("reset_outputs", 32'({tx_start, tx_data, grant, ack, busy}), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    int n, a0;
    #2 rst_n = 1'b0;
    #1 chk("reset_outputs", 32'({tx_start, tx_data, grant, ack, busy}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      chk("idle_quiet", 32'({tx_start, tx_data, grant, ack, busy}), 0);
    end
    // single request from requester 2
    a0 = acks;
    set_word(2, 7'h2D);
    req = 4'b0100;
    q.push_back('{4'b0100, 7'h2D});
    wait_start();
    req = '0;
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("busy_len", 32'(n), 11);
    chk("single_acks", 32'(acks - a0), 1);
    // full contention from a fresh pointer
    do_reset();
    for (int i = 0; i < N; i++) set_word(i, 7'(8'h10 + i));
    starts.delete();
    a0 = acks;
    for (int i = 0; i < 5; i++) q.push_back('{4'(1 << (i % N)), 7'(8'h10 + (i % N))});
    req = 4'b1111;
    n = 0;
    while (starts.size() < 5 && n < 120) begin
      n++;
      @(negedge clk);
    end
    req = '0;
    chk("rr_starts", 32'(starts.size()), 5);
    for (int i = 1; i < starts.size(); i++) chk("rr_spacing", 32'(starts[i] - starts[i-1]), 12);
    wait_idle();
    chk("rr_acks", 32'(acks - a0), 5);
    // data stability: slice changes after capture are ignored
    do_reset();
    set_word(1, 7'h55);
    req = 4'b0010;
    q.push_back('{4'b0010, 7'h55});
    wait_start();
    repeat (4) @(negedge clk);
    set_word(1, 7'h7E);
    req = '0;
    repeat (15) begin
      @(negedge clk);
      chk("data_hold", 32'(tx_data), 32'h55);
    end
    // early drop by requester 3: frame completes, no re-grant
    do_reset();
    a0 = acks;
    set_word(3, 7'h33);
    req = 4'b1000;
    q.push_back('{4'b1000, 7'h33});
    wait_start();
    repeat (3) @(negedge clk);
    req = '0;
    repeat (30) @(negedge clk);
    chk("drop_acks", 32'(acks - a0), 1);
    chk("drop_grant", 32'(grant), 0);
    // reset mid-frame: no ack, pointer returns to 0 so requester 1 wins again
    do_reset();
    a0 = acks;
    set_word(1, 7'h21);
    set_word(3, 7'h63);
    req = 4'b1010;
    q.push_back('{4'b0010, 7'h21});
    wait_start();
    repeat (4) @(negedge clk);
    q.push_back('{4'b0010, 7'h21});
    do_reset();
    wait_start();
    chk("midreset_no_ack", 32'(acks - a0), 0);
    req = '0;
    wait_idle();
    chk("midreset_acks", 32'(acks - a0), 1);
    chk("queue_drained", 32'(q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/serial_tx_scheduler.md
Name: serial_tx_scheduler

Overview:
- Round-robin scheduler that shares one serial_data_transmitter between NUM_REQ requesters.
- Arbitrates pending requests and captures the winner's parallel word.
- Drives the transmitter's start/data inputs for one frame, then acknowledges the requester.
- Sits between client blocks and the transmitter's in_data/start_transmit inputs; serial_out bypasses this block.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
DATA_W, 7, parallel word width; matches transmitter in_data
FRAME_CYCLES, 10, clock cycles the transmitter needs per frame, measured from the start pulse (>=2)
GAP_CYCLES, 1, idle cycles enforced between frames (>=0)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req  input  NUM_REQ  per-requester request level; held until ack
req_data  input  NUM_REQ*DATA_W  packed words; requester i occupies bits [i*DATA_W +: DATA_W]
tx_start  output  1  one-cycle start pulse to transmitter start_transmit
tx_data  output  DATA_W  word to transmitter in_data; stable for the whole frame
grant  output  NUM_REQ  one-hot owner of the current frame; 0 when idle
ack  output  NUM_REQ  one-cycle pulse on the owner's bit at frame end
busy  output  1  high in LOAD, SEND and GAP

Behaviour:
- Reset is asynchronous and dominant; it may hit any state.
  - Immediately drives state=IDLE and zeroes tx_start, tx_data, grant, ack, busy and the counter.
  - Sets the round-robin pointer so req[0] has highest priority.
  - A frame in flight is abandoned; no ack is issued.
- States: IDLE, LOAD, SEND, GAP.
- IDLE:
  - On each clk edge, if req != 0, select the first set bit scanning from ptr upward with wrap-around (ptr, ptr+1, ..., NUM_REQ-1, 0, ..., ptr-1).
  - Register grant (one-hot winner), capture tx_data from the winner's req_data slice, set ptr = winner+1 mod NUM_REQ, go to LOAD.
  - If req == 0, stay in IDLE; outputs unchanged (all 0).
- LOAD: exactly one cycle.
  - tx_start=1, tx_data valid, busy=1.
  - Counter loaded with FRAME_CYCLES-2; go to SEND.
- SEND: FRAME_CYCLES-1 cycles.
  - tx_start=0; the counter decrements each cycle.
  - In the cycle the counter is 0: ack = grant for one cycle.
  - Next state is GAP if GAP_CYCLES>0, else IDLE.
  - Total window from tx_start high to the end of the ack cycle is FRAME_CYCLES cycles.
- GAP: GAP_CYCLES cycles.
  - grant=0, tx_data holds its last value, busy=1; then go to IDLE.
- grant is cleared on leaving SEND.
- tx_data changes only on capture in IDLE; requester data changes after capture are ignored.
- Deasserting req mid-frame does not abort the frame; ack still pulses.
- A requester still holding req after its ack is eligible again, but the pointer has moved past it. Under full load each requester gets one frame per NUM_REQ frames, so there is no starvation.
- Requests that arrive during LOAD/SEND/GAP wait; they are sampled only in IDLE.
- Back-to-back frame period = 1 (IDLE) + FRAME_CYCLES + GAP_CYCLES cycles.
- Exactly one tx_start pulse per grant; tx_start and ack are never high in the same cycle.
- Counter width = $clog2(max(FRAME_CYCLES,GAP_CYCLES+1)); no overflow for legal parameters.

Test Plan:
- Reset check: assert rst_n=0 at any time -> tx_start, tx_data, grant, ack and busy all read 0 in the same cycle. Release, with req=0 for 20 cycles -> outputs remain 0.
- Single request: req=4'b0100, req_data slice 2 = 7'h2D.
  - Next edge: tx_start=1 for exactly 1 cycle, tx_data=7'h2D, grant=4'b0100.
  - ack=4'b0100 for 1 cycle, 9 cycles after the tx_start cycle.
  - busy high for 11 cycles.
- Full contention: req=4'b1111 held after reset.
  - Grants in order 0,1,2,3,0; tx_start pulses spaced 12 cycles apart.
  - Each ack matches the preceding grant.
- Data stability: after grant to requester 1 with 7'h55, change its slice to 7'h7E mid-SEND -> tx_data stays 7'h55 until the next capture.
- Early request drop: requester 3 deasserts req 3 cycles after tx_start -> frame runs to completion, ack[3] pulses at the normal cycle, and no re-grant to requester 3.
- Reset mid-frame: pull rst_n low 5 cycles into SEND with req=4'b1010 pending -> outputs 0 immediately and no ack. After release, the first grant goes to requester 1 (pointer reset to 0).
